// File: rtl/exc_pkg.sv
// Shared constants for the MEM-stage exception arbiter: ExcCodes, cause-vector
// bit positions, CP0 field positions and the arbiter FSM state type.
package exc_pkg;

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0A;
    localparam logic [4:0] EXC_OV   = 5'h0C;
    localparam logic [4:0] EXC_ERET = 5'h1E;
    localparam logic [4:0] EXC_NONE = 5'h1F;

    localparam int BIT_SYS    = 0;
    localparam int BIT_BP     = 1;
    localparam int BIT_ERET   = 2;
    localparam int BIT_OV     = 3;
    localparam int BIT_ADEL_D = 4;
    localparam int BIT_ADEL_F = 5;
    localparam int BIT_RI     = 6;
    localparam int BIT_BTS    = 7;

    localparam int ST_IE_BIT    = 0;
    localparam int ST_EXL_BIT   = 1;
    localparam int ST_IM_LSB    = 8;
    localparam int CA_IP_LSB    = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_REDIRECT = 2'd2
    } exc_state_e;

    // Cause-vector bit index to ExcCode; bit 7 and anything unknown is EXC_NONE.
    function automatic logic [4:0] code_of_bit(input int idx);
        logic [4:0] code;
        case (idx)
            BIT_SYS:    code = EXC_SYS;
            BIT_BP:     code = EXC_BP;
            BIT_ERET:   code = EXC_ERET;
            BIT_OV:     code = EXC_OV;
            BIT_ADEL_D: code = EXC_ADEL;
            BIT_ADEL_F: code = EXC_ADEL;
            BIT_RI:     code = EXC_RI;
            default:    code = EXC_NONE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// Fixed-priority cause encoder: interrupt first, then the lowest set bit of
// the synchronous exception vector.
module exc_prio_enc
    import exc_pkg::*;
#(
    parameter int NUM_SRC = 8
) (
    input  logic [NUM_SRC-1:0] exc_vec,
    input  logic               int_pend,
    output logic [4:0]         exc_code,
    output logic               is_eret
);

    logic [4:0] vec_code_s;

    // Scan downward so the lowest set bit is the last one to overwrite.
    always_comb begin
        vec_code_s = EXC_NONE;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            vec_code_s = exc_vec[i] ? code_of_bit(i) : vec_code_s;
        end
    end

    // Interrupt overrides everything, including ERET.
    always_comb begin
        exc_code = EXC_NONE;
        is_eret  = 1'b0;
        if (int_pend) begin
            exc_code = EXC_INT;
            is_eret  = 1'b0;
        end else begin
            exc_code = vec_code_s;
            is_eret  = (vec_code_s == EXC_ERET);
        end
    end

endmodule

// File: rtl/exc_arbiter.sv
// MEM-stage exception arbiter: selects a cause, pulses the CP0 commit, holds a
// flush and then hands a redirect PC to IF. Optional macro: EXC_INT_SYNC_EN.
module exc_arbiter
    import exc_pkg::*;
#(
    parameter int          NUM_SRC      = 8,
    parameter int          NUM_HWINT    = 6,
    parameter logic [31:0] VEC_BASE     = 32'hBFC00380,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 valid_i,
    input  logic                 stall_i,
    input  logic [31:0]          pc_i,
    input  logic [31:0]          instr_i,
    input  logic [31:0]          badvaddr_i,
    input  logic [NUM_SRC-1:0]   exc_vec_i,
    input  logic                 in_delayslot_i,
    input  logic                 we_mem_i,
    input  logic [3:0]           wen_i,
    input  logic [NUM_HWINT-1:0] hw_int_i,
    input  logic [31:0]          cp0_status_i,
    input  logic [31:0]          cp0_cause_i,
    input  logic [31:0]          cp0_epc_i,
    input  logic                 redirect_ready_i,
    output logic [3:0]           wen_o,
    output logic                 flush_o,
    output logic                 busy_o,
    output logic                 cp0_we_o,
    output logic [31:0]          cp0_epc_o,
    output logic [31:0]          cp0_badvaddr_o,
    output logic                 cp0_bd_o,
    output logic [4:0]           exc_code_o,
    output logic [31:0]          exc_instr_o,
    output logic                 redirect_valid_o,
    output logic [31:0]          redirect_pc_o
);

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    exc_state_e  state_r, state_nx_s;
    logic [3:0]  cnt_r, cnt_nx_s;
    logic        flush_r, flush_nx_s;
    logic        busy_r, busy_nx_s;
    logic        rv_r, rv_nx_s;
    logic        cp0_we_r, cp0_we_nx_s;
    logic [31:0] epc_r, bva_r, instr_r, rpc_r;
    logic        bd_r;
    logic [4:0]  code_r;

    logic [NUM_HWINT-1:0] hw_int_s;
    logic [7:0]  hw_ip_s, ip_s, im_s;
    logic        int_pend_s, take_s, is_eret_s;
    logic [4:0]  exc_code_s;

`ifdef EXC_INT_SYNC_EN
    logic [NUM_HWINT-1:0] sync1_r, sync2_r;

    // Two-flop synchronizer for the asynchronous interrupt lines.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_r <= '0;
            sync2_r <= '0;
        end else begin
            sync1_r <= hw_int_i;
            sync2_r <= sync1_r;
        end
    end

    assign hw_int_s = sync2_r;
`else
    assign hw_int_s = hw_int_i;
`endif

    // Hardware lines occupy IP[7:2]; NUM_HWINT is expected to be at most 6.
    assign hw_ip_s    = 8'({hw_int_s, 2'b00});
    assign ip_s       = cp0_cause_i[CA_IP_LSB +: 8] | hw_ip_s;
    assign im_s       = cp0_status_i[ST_IM_LSB +: 8];
    assign int_pend_s = cp0_status_i[ST_IE_BIT] & ~cp0_status_i[ST_EXL_BIT] & (|(ip_s & im_s));
    assign take_s     = (state_r == ST_IDLE) & valid_i & ~stall_i & ((|exc_vec_i) | int_pend_s);

    logic unused_s;
    assign unused_s = ^{cp0_status_i[31:16], cp0_status_i[7:2], cp0_cause_i[31:16], cp0_cause_i[7:0]};

    exc_prio_enc #(.NUM_SRC(NUM_SRC)) u_prio (
        .exc_vec  (exc_vec_i),
        .int_pend (int_pend_s),
        .exc_code (exc_code_s),
        .is_eret  (is_eret_s)
    );

    // Stores of the excepting instruction never reach memory.
    always_comb begin
        if (we_mem_i && valid_i && (state_r == ST_IDLE) && !take_s) begin
            wen_o = wen_i;
        end else begin
            wen_o = 4'b0000;
        end
    end

    // Next-state and next registered-output logic.
    always_comb begin
        state_nx_s  = state_r;
        cnt_nx_s    = cnt_r;
        flush_nx_s  = flush_r;
        rv_nx_s     = rv_r;
        cp0_we_nx_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (take_s) begin
                    state_nx_s  = ST_FLUSH;
                    cnt_nx_s    = FLUSH_LOAD;
                    flush_nx_s  = 1'b1;
                    cp0_we_nx_s = ~is_eret_s;
                end else begin
                    flush_nx_s = 1'b0;
                    rv_nx_s    = 1'b0;
                end
            end
            ST_FLUSH: begin
                if (cnt_r == 4'd0) begin
                    state_nx_s = ST_REDIRECT;
                    flush_nx_s = 1'b0;
                    rv_nx_s    = 1'b1;
                end else begin
                    cnt_nx_s = cnt_r - 4'd1;
                end
            end
            ST_REDIRECT: begin
                if (rv_r && redirect_ready_i) begin
                    state_nx_s = ST_IDLE;
                    rv_nx_s    = 1'b0;
                end else begin
                    rv_nx_s = 1'b1;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                cnt_nx_s   = 4'd0;
                flush_nx_s = 1'b0;
                rv_nx_s    = 1'b0;
            end
        endcase
        busy_nx_s = (state_nx_s != ST_IDLE);
    end

    // FSM state and control output registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r  <= ST_IDLE;
            cnt_r    <= 4'd0;
            flush_r  <= 1'b0;
            busy_r   <= 1'b0;
            rv_r     <= 1'b0;
            cp0_we_r <= 1'b0;
        end else begin
            state_r  <= state_nx_s;
            cnt_r    <= cnt_nx_s;
            flush_r  <= flush_nx_s;
            busy_r   <= busy_nx_s;
            rv_r     <= rv_nx_s;
            cp0_we_r <= cp0_we_nx_s;
        end
    end

    // Event payload captured at the take edge and held until the next take.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            epc_r   <= 32'd0;
            bva_r   <= 32'd0;
            bd_r    <= 1'b0;
            code_r  <= 5'd0;
            instr_r <= 32'd0;
            rpc_r   <= 32'd0;
        end else if (take_s) begin
            epc_r   <= in_delayslot_i ? (pc_i - 32'd4) : pc_i;
            bd_r    <= in_delayslot_i;
            code_r  <= exc_code_s;
            instr_r <= instr_i;
            rpc_r   <= is_eret_s ? cp0_epc_i : VEC_BASE;
            if (exc_code_s == EXC_ADEL) begin
                bva_r <= exc_vec_i[BIT_ADEL_D] ? badvaddr_i : pc_i;
            end else begin
                bva_r <= bva_r;
            end
        end else begin
            epc_r <= epc_r;
        end
    end

    assign flush_o          = flush_r;
    assign busy_o           = busy_r;
    assign cp0_we_o         = cp0_we_r;
    assign cp0_epc_o        = epc_r;
    assign cp0_badvaddr_o   = bva_r;
    assign cp0_bd_o         = bd_r;
    assign exc_code_o       = code_r;
    assign exc_instr_o      = instr_r;
    assign redirect_valid_o = rv_r;
    assign redirect_pc_o    = rpc_r;

endmodule
